// File: rtl/ram_agu_ctrl.sv
// ram_agu_ctrl: sequences Length RAM requests from one latched config, direct strided or index-driven.
module ram_agu_ctrl #(
  parameter int WIDTH_LENGTH = 8,
  parameter int WIDTH_ADDR   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Cfg_Valid,
  input  logic [1:0]              I_Cfg_Mode,
  input  logic                    I_Cfg_Decrement,
  input  logic                    I_Cfg_Indirect,
  input  logic [WIDTH_LENGTH-1:0] I_Cfg_Length,
  input  logic [WIDTH_LENGTH-1:0] I_Cfg_Stride,
  input  logic [WIDTH_LENGTH-1:0] I_Cfg_Base,
  output logic                    O_Cfg_Ready,
  input  logic                    I_Idx_Valid,
  input  logic [WIDTH_LENGTH-1:0] I_Idx,
  output logic                    O_Idx_Ready,
  output logic                    O_Req,
  output logic [WIDTH_ADDR-1:0]   O_Addr,
  output logic [1:0]              O_Size,
  input  logic                    I_Ack,
  output logic                    O_Busy,
  output logic                    O_Done,
  output logic                    O_Err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic dec_q, dec_d, ind_q, ind_d, req_q, req_d, done_q, done_d, err_q, err_d;
  logic [WIDTH_LENGTH-1:0] base_q, base_d, stride_q, stride_d, rem_q, rem_d, e_q, e_d;
  logic [WIDTH_LENGTH-1:0] e_nx, ind_el;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic ack, last, take;

  function automatic logic [WIDTH_ADDR-1:0] byte_addr(input logic [WIDTH_LENGTH-1:0] el, input logic [1:0] m);
    return WIDTH_ADDR'(el) << m;
  endfunction

  assign ack         = I_Ack & req_q;
  assign last        = (state_q == RUN) & ack & (rem_q == WIDTH_LENGTH'(1));
  // in indirect mode the request/address registers are the single-entry index buffer
  assign O_Idx_Ready = (state_q == RUN) & ind_q & (~req_q | ack) & ~last;
  assign take        = O_Idx_Ready & I_Idx_Valid;
  assign O_Cfg_Ready = state_q == IDLE;
  assign e_nx        = dec_q ? e_q - stride_q : e_q + stride_q;
  assign ind_el      = dec_q ? base_q - I_Idx : base_q + I_Idx;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dec_d    = dec_q;
    ind_d    = ind_q;
    base_d   = base_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    e_d      = e_q;
    req_d    = req_q;
    addr_d   = addr_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (I_Cfg_Valid) begin
        if (I_Cfg_Mode == 2'b11) err_d = 1'b1;
        else begin
          mode_d   = I_Cfg_Mode;
          dec_d    = I_Cfg_Decrement;
          ind_d    = I_Cfg_Indirect;
          base_d   = I_Cfg_Base;
          stride_d = I_Cfg_Stride;
          rem_d    = I_Cfg_Length;
          e_d      = I_Cfg_Base;
          state_d  = (I_Cfg_Length == '0) ? DONE : RUN;
          req_d    = (I_Cfg_Length != '0) & ~I_Cfg_Indirect;
          addr_d   = byte_addr(I_Cfg_Base, I_Cfg_Mode);
        end
      end
      RUN: begin
        rem_d = ack ? rem_q - WIDTH_LENGTH'(1) : rem_q;
        if (last) begin
          state_d = DONE;
          req_d   = 1'b0;
        end else if (ind_q) begin
          req_d  = take | (req_q & ~ack);
          addr_d = take ? byte_addr(ind_el, mode_q) : addr_q;
        end else if (ack) begin
          e_d    = e_nx;
          addr_d = byte_addr(e_nx, mode_q);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      dec_q    <= 1'b0;
      ind_q    <= 1'b0;
      base_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      e_q      <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dec_q    <= dec_d;
      ind_q    <= ind_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      e_q      <= e_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign O_Req  = req_q;
  assign O_Addr = addr_q;
  assign O_Size = mode_q;
  assign O_Busy = state_q == RUN;
  assign O_Done = done_q;
  assign O_Err  = err_q;
endmodule

// File: tb/tb_ram_agu_ctrl.sv
// tb_ram_agu_ctrl: directed stimulus, per-cycle transaction model compare plus literal address checks.
module tb_ram_agu_ctrl;
  logic clock = 1'b0, reset = 1'b0;
  logic cfg_valid = 0, cfg_dec = 0, cfg_ind = 0, idx_valid = 0, ack = 0;
  logic [1:0] cfg_mode = 0;
  logic [7:0] cfg_len = 0, cfg_stride = 0, cfg_base = 0, idx = 0;
  logic cfg_ready, idx_ready, req, busy, done, err;
  logic [11:0] addr;
  logic [1:0] size;
  int checks = 0, failures = 0;
  int reqcnt = 0, donecnt = 0;
  int acc_log[$];
  logic run = 0, e_req = 0, e_done = 0, e_err = 0, m_dec = 0, m_ind = 0, e_idx_rdy;
  logic idle, ackd, take, n_done, n_err;
  int m_mode = 0, m_base = 0, m_stride = 0, rem = 0, k = 0, e_addr = 0;

  ram_agu_ctrl #(.WIDTH_LENGTH(8), .WIDTH_ADDR(12)) dut (
    .clock(clock), .reset(reset),
    .I_Cfg_Valid(cfg_valid), .I_Cfg_Mode(cfg_mode), .I_Cfg_Decrement(cfg_dec), .I_Cfg_Indirect(cfg_ind),
    .I_Cfg_Length(cfg_len), .I_Cfg_Stride(cfg_stride), .I_Cfg_Base(cfg_base), .O_Cfg_Ready(cfg_ready),
    .I_Idx_Valid(idx_valid), .I_Idx(idx), .O_Idx_Ready(idx_ready),
    .O_Req(req), .O_Addr(addr), .O_Size(size), .I_Ack(ack),
    .O_Busy(busy), .O_Done(done), .O_Err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ba(input int el, input int m);
    return (((el % 256) + 256) % 256) << m;
  endfunction

  // Cycle model: compare current outputs, then advance on the inputs the next edge will sample.
  always @(negedge clock) begin
    if (!reset) begin
      run = 0; e_req = 0; e_done = 0; e_err = 0; m_mode = 0; e_addr = 0; rem = 0; m_ind = 0;
    end
    e_idx_rdy = run && m_ind && (!e_req || ack) && !(ack && e_req && rem == 1);
    chk("req", int'(req), int'(e_req));
    if (e_req) chk("addr", int'(addr), e_addr);
    chk("size", int'(size), m_mode);
    chk("busy", int'(busy), int'(run));
    chk("done", int'(done), int'(e_done));
    chk("err", int'(err), int'(e_err));
    chk("cfg_ready", int'(cfg_ready), int'(!run && !e_done));
    chk("idx_ready", int'(idx_ready), int'(e_idx_rdy));
    if (req) reqcnt++;
    if (done) donecnt++;
    if (req && ack) acc_log.push_back(int'(addr));
    if (reset) begin
      idle = !run && !e_done;
      ackd = ack && e_req;
      take = idx_valid && e_idx_rdy;
      n_done = 0; n_err = 0;
      if (idle && cfg_valid) begin
        if (cfg_mode == 2'b11) n_err = 1;
        else begin
          m_mode = int'(cfg_mode); m_dec = cfg_dec; m_ind = cfg_ind;
          m_base = int'(cfg_base); m_stride = int'(cfg_stride); rem = int'(cfg_len); k = 0;
          if (rem == 0) n_done = 1;
          else begin
            run = 1; e_req = !cfg_ind;
            if (!cfg_ind) e_addr = ba(m_base, m_mode);
          end
        end
      end else if (run) begin
        if (ackd) begin rem--; k++; end
        if (ackd && rem == 0) begin run = 0; e_req = 0; n_done = 1; end
        else if (m_ind) begin
          if (take) begin
            e_req = 1;
            e_addr = ba(m_dec ? m_base - int'(idx) : m_base + int'(idx), m_mode);
          end else if (ackd) e_req = 0;
        end else if (ackd) e_addr = ba(m_dec ? m_base - k * m_stride : m_base + k * m_stride, m_mode);
      end
      e_done = n_done; e_err = n_err;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  task automatic wait_done(input int bound);
    int i;
    for (i = 0; i < bound && !done; i++) step();
    chk("done_timeout", int'(i < bound), 1);
  endtask

  task automatic cfg(input int m, input logic d, input logic ind, input int len, input int st, input int b);
    cfg_valid = 1; cfg_mode = 2'(m); cfg_dec = d; cfg_ind = ind;
    cfg_len = 8'(len); cfg_stride = 8'(st); cfg_base = 8'(b);
  endtask

  task automatic chk_log(input int n, input int a0, input int a1, input int a2);
    int ex[3];
    ex = '{a0, a1, a2};
    chk("log_len", acc_log.size(), n);
    for (int i = 0; i < n && i < acc_log.size(); i++) chk("log_addr", acc_log[i], ex[i]);
  endtask

  task automatic clr();
    acc_log.delete(); reqcnt = 0; donecnt = 0;
  endtask

  initial begin
    step(2);
    chk("rst_req", int'(req), 0); chk("rst_addr", int'(addr), 0); chk("rst_busy", int'(busy), 0);
    reset = 1; step();
    // direct increment, continuous ack
    clr(); ack = 1; cfg(2, 0, 0, 3, 3, 4); step(); cfg_valid = 0;
    chk("d_size", int'(size), 2); chk("d_first", int'(addr), 'h010);
    wait_done(10); step(); ack = 0;
    chk_log(3, 'h010, 'h01C, 'h028); chk("d_donecnt", donecnt, 1);
    // decrement, wrap, two cycles of backpressure
    clr(); cfg(0, 1, 0, 3, 2, 1); step(); cfg_valid = 0; step(2); ack = 1;
    wait_done(10); step(); ack = 0;
    chk_log(3, 'h001, 'h0FF, 'h0FD); chk("b_reqcnt", reqcnt, 5);
    // indirect with a gap between indices
    clr(); ack = 1; cfg(1, 0, 1, 2, 9, 'h10); step(); cfg_valid = 0;
    idx_valid = 1; idx = 8'h02; step(); idx_valid = 0;
    chk("i_addr0", int'(addr), 'h024); step(3);
    chk("i_gap_req", int'(req), 0);
    idx_valid = 1; idx = 8'h05; step(); idx_valid = 0;
    wait_done(10); step(); ack = 0;
    chk_log(2, 'h024, 'h02A, 0); chk("i_reqcnt", reqcnt, 2);
    // reserved mode
    cfg(3, 0, 0, 4, 1, 1); step(); cfg_valid = 0;
    chk("e_err", int'(err), 1); chk("e_busy", int'(busy), 0); step();
    chk("e_err_clr", int'(err), 0);
    // zero length
    clr(); cfg(0, 0, 0, 0, 1, 1); step(); cfg_valid = 0;
    chk("z_done", int'(done), 1); step(); chk("z_reqcnt", reqcnt, 0);
    // second configuration held during a run
    clr(); cfg(0, 0, 0, 3, 1, 0); step(); cfg(0, 0, 0, 1, 1, 'h20); step(2);
    chk("h_rdy_busy", int'(cfg_ready), 0); ack = 1;
    wait_done(10); chk("h_rdy_done", int'(cfg_ready), 0); step();
    chk("h_rdy_idle", int'(cfg_ready), 1); step(); cfg_valid = 0;
    chk("h_req", int'(req), 1); chk("h_addr", int'(addr), 'h020);
    wait_done(10); step();
    // reset after the second ack of a five-access run
    clr(); cfg(0, 0, 0, 5, 1, 0); step(); cfg_valid = 0; step(2);
    reset = 0; #1;
    chk("r_req", int'(req), 0); chk("r_busy", int'(busy), 0); chk("r_addr", int'(addr), 0);
    step(2); reset = 1; step(3);
    chk("r_nodone", donecnt, 0);
    cfg(0, 0, 0, 1, 1, 7); step(); cfg_valid = 0;
    chk("r_restart", int'(addr), 'h007);
    wait_done(10); step(2); ack = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_agu_ctrl.md
# ram_agu_ctrl

Sequencer that drives one RAM port for a load/store stream. It accepts one decoded memory configuration (mode, decrement, indirect, length, stride, base), then issues exactly `Length` address requests to the RAM port under a request/acknowledge handshake and signals completion. It sits between the configuration decoder and the RAM access port of a compute-element memory tile. In indirect mode it consumes one index token per access instead of striding.

## Interface
Parameters:
- WIDTH_LENGTH, 8, width of the length, stride, base and index fields; also the element-address width.
- WIDTH_ADDR, 12, byte-address width; must be ≥ WIDTH_LENGTH+2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset is asynchronous and active-low.
- I_Cfg_Valid  in  1  configuration present.
- I_Cfg_Mode  in  2  access size: 00 8-bit, 01 16-bit, 10 32-bit, 11 reserved.
- I_Cfg_Decrement  in  1  step downward instead of upward.
- I_Cfg_Indirect  in  1  use the index stream for addressing.
- I_Cfg_Length  in  WIDTH_LENGTH  number of accesses.
- I_Cfg_Stride  in  WIDTH_LENGTH  element step for direct mode.
- I_Cfg_Base  in  WIDTH_LENGTH  base element address.
- O_Cfg_Ready  out  1  configuration accepted this cycle if valid.
- I_Idx_Valid  in  1  index token present.
- I_Idx  in  WIDTH_LENGTH  index value.
- O_Idx_Ready  out  1  index consumed this cycle if valid.
- O_Req  out  1  RAM request.
- O_Addr  out  WIDTH_ADDR  byte address.
- O_Size  out  2  latched mode.
- I_Ack  in  1  RAM accepted the current request.
- O_Busy  out  1  a sequence is in progress.
- O_Done  out  1  one-cycle pulse marking sequence completion.
- O_Err  out  1  one-cycle pulse: reserved mode rejected.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state IDLE. O_Req, O_Busy, O_Done, O_Err = 0. O_Addr, O_Size = 0. Index buffer empty. Counters = 0. An in-flight sequence is dropped with no O_Done.
- IDLE:
  - O_Cfg_Ready = 1.
  - On I_Cfg_Valid, latch all fields.
  - Mode 11: pulse O_Err next cycle, stay IDLE, latch nothing.
  - Length 0: go to DONE with no requests.
  - Otherwise: go to RUN with remaining count = Length and element pointer e = Base.
- RUN:
  - O_Busy = 1 and O_Cfg_Ready = 0. A configuration arriving while busy is not accepted; the producer holds it.
- Direct addressing:
  - O_Req = 1 throughout RUN.
  - Element address = e.
  - On each I_Ack: e ← e ± Stride, modulo 2^WIDTH_LENGTH (wraps silently).
- Indirect addressing:
  - Single-entry index buffer.
  - O_Idx_Ready = RUN & (buffer empty | I_Ack).
  - O_Req = RUN & buffer full.
  - Element address = Base ± buffered index, modulo 2^WIDTH_LENGTH (− when Decrement).
  - Stride is ignored.
  - Indices offered outside RUN are not consumed.
- Byte address:
  - O_Addr = zero-extend(element address) << Mode.
  - O_Size = latched Mode.
- Completion:
  - Each I_Ack decrements the remaining count.
  - An I_Ack with remaining = 1 moves the state to DONE. O_Req is 0 the following cycle.
- DONE: O_Done = 1 for exactly one cycle, O_Busy = 0, then IDLE.
- I_Ack while O_Req = 0 is ignored.

## Timing
- O_Req, O_Addr, O_Size, O_Done and O_Err are registered.
- O_Cfg_Ready and O_Idx_Ready are combinational from state, buffer and I_Ack.
- Direct latency: configuration accepted at edge N. O_Req = 1 with address Base<<Mode in cycle N+1.
- Indirect latency: index consumed at edge M. O_Req = 1 with its address in cycle M+1.
- Handshake: while O_Req = 1 and I_Ack = 0, O_Addr and O_Size are held stable.
- Throughput: with I_Ack = 1 every cycle, one access per cycle in both modes. In indirect mode this requires an index on each cycle; the index buffer reloads on the same edge as the ack.
- Simultaneous final I_Ack and incoming I_Idx_Valid: the index is not consumed (state leaves RUN).
- Sequence of L accesses with continuous ack: O_Done asserts in cycle N+L+1. A new configuration is acceptable from cycle N+L+2.

## Test plan
- Direct increment: Mode 10, Base 4, Stride 3, Length 3, I_Ack held 1 -> O_Addr 0x010, 0x01C, 0x028 on consecutive cycles; O_Done pulses once; O_Size = 10.
- Decrement with wrap and backpressure: Mode 00, Base 1, Stride 2, Length 3, I_Ack low for 2 cycles on the first request -> O_Addr 0x001 held 3 cycles, then 0x0FF, 0x0FD.
- Indirect gaps: Mode 01, Base 0x10, Length 2, indices 0x02 then 0x05 with a 3-cycle gap between them -> O_Addr 0x024, then 0x02A; O_Req = 0 during the gap.
- Edge configurations:
  - Mode 11 -> O_Err pulse, O_Busy stays 0.
  - Length 0 -> O_Done pulse with no O_Req.
  - Second configuration held during RUN -> O_Cfg_Ready 0 until IDLE, then accepted.
- Mid-run reset: assert reset after the second ack of Length 5 -> all outputs 0 immediately, no O_Done; the next configuration restarts from its own Base.
